// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: scan-list sequencer for the MAX10 modular-ADC Avalon-ST command/response ports.
// Build option ADC_AVG_EN: per-slot accumulation over 2**AVG_LOG2 scans instead of direct overwrite.
module adc_scan_ctrl #(
    parameter int NSLOT    = 4,
    parameter int MAX_OUT  = 2,
    parameter int SCAN_GAP = 16,
    parameter int AVG_LOG2 = 2,
    localparam int SW      = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic               clock_clk,
    input  logic               reset_sink_reset,
    input  logic               start,
    input  logic               continuous,
    input  logic [NSLOT*5-1:0] chan_list,
    output logic               command_valid,
    output logic [4:0]         command_channel,
    output logic               command_startofpacket,
    output logic               command_endofpacket,
    input  logic               command_ready,
    input  logic               response_valid,
    input  logic [4:0]         response_channel,
    input  logic [11:0]        response_data,
    input  logic               response_startofpacket,
    input  logic               response_endofpacket,
    input  logic               rd_en,
    input  logic [SW-1:0]      rd_slot,
    output logic [11:0]        rd_data,
    output logic               rd_fresh,
    output logic               busy,
    output logic               scan_done,
    output logic               seq_err,
    input  logic               clr_err
);

    localparam int PW = $clog2(NSLOT + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, GAP} state_t;

    state_t             state_q, state_d;
    logic [NSLOT*5-1:0] chans_q, chans_d;
    logic [PW-1:0]      iss_ptr_q, iss_ptr_d, rsp_ptr_q, rsp_ptr_d;
    logic [OW-1:0]      outst_q, outst_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [11:0]        result_q [NSLOT];
    logic [11:0]        result_d [NSLOT];
    logic [NSLOT-1:0]   fresh_q, fresh_d;
    logic [11:0]        rd_data_q, rd_data_d;
    logic               rd_fresh_q, rd_fresh_d;
    logic               seq_err_q, seq_err_d;

    logic [4:0] iss_chan, rsp_chan;
    logic       cmd_valid, fire, rsp_acc, err_ev, done, scan_load;
    logic       unused_inputs;

`ifdef ADC_AVG_EN
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    logic [AW-1:0] acc_q [NSLOT];
    logic [AW-1:0] acc_d [NSLOT];
    logic [CW-1:0] scnt_q, scnt_d;
    logic          batch_last;
    assign batch_last = (scnt_q == CW'((1 << AVG_LOG2) - 1));
`endif

    assign unused_inputs = &{1'b0, response_startofpacket, response_endofpacket, (AVG_LOG2 != 0)};

    always_comb begin
        iss_chan = '0;
        rsp_chan = '0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            if (iss_ptr_q == PW'(k)) iss_chan = chans_q[5*k +: 5];
            if (rsp_ptr_q == PW'(k)) rsp_chan = chans_q[5*k +: 5];
        end
    end

    assign cmd_valid = (state_q == ISSUE) && (outst_q < OW'(MAX_OUT));
    assign fire      = cmd_valid && command_ready;
    assign rsp_acc   = response_valid && (outst_q != '0);
    assign err_ev    = (response_valid && (outst_q == '0)) ||
                       (rsp_acc && (response_channel != rsp_chan));
    assign done      = (state_q == DRAIN) && (outst_q == '0);

    always_comb begin
        state_d    = state_q;
        chans_d    = chans_q;
        iss_ptr_d  = iss_ptr_q;
        rsp_ptr_d  = rsp_ptr_q;
        outst_d    = outst_q;
        gap_d      = gap_q;
        result_d   = result_q;
        fresh_d    = fresh_q;
        rd_data_d  = rd_data_q;
        rd_fresh_d = rd_fresh_q;
        seq_err_d  = seq_err_q;
        scan_load  = 1'b0;
`ifdef ADC_AVG_EN
        acc_d      = acc_q;
        scnt_d     = scnt_q;
`endif

        // Read clears fresh before response handling so a same-cycle write re-sets it.
        if (rd_en) begin
            rd_data_d  = '0;
            rd_fresh_d = 1'b0;
            for (int unsigned k = 0; k < NSLOT; k++) begin
                if (rd_slot == SW'(k)) begin
                    rd_data_d  = result_q[k];
                    rd_fresh_d = fresh_q[k];
                    fresh_d[k] = 1'b0;
                end
            end
        end

        if (rsp_acc) begin
            for (int unsigned k = 0; k < NSLOT; k++) begin
                if (rsp_ptr_q == PW'(k)) begin
`ifdef ADC_AVG_EN
                    acc_d[k] = acc_q[k] + AW'(response_data);
`else
                    result_d[k] = response_data;
                    fresh_d[k]  = 1'b1;
`endif
                end
            end
            rsp_ptr_d = rsp_ptr_q + PW'(1);
        end

        if (fire) iss_ptr_d = iss_ptr_q + PW'(1);

        case ({fire, rsp_acc})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (err_ev)       seq_err_d = 1'b1;
        else if (clr_err) seq_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ISSUE;
                    scan_load = 1'b1;
                end
            end
            ISSUE: begin
                if (fire && (iss_ptr_q == PW'(NSLOT - 1))) state_d = DRAIN;
            end
            DRAIN: begin
                if (outst_q == '0) begin
                    state_d = continuous ? GAP : IDLE;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (!continuous) begin
                    state_d = IDLE;
                end else if (gap_q == GW'(SCAN_GAP - 1)) begin
                    state_d   = ISSUE;
                    scan_load = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (scan_load) begin
            chans_d   = chan_list;
            iss_ptr_d = '0;
            rsp_ptr_d = '0;
            outst_d   = '0;
        end

`ifdef ADC_AVG_EN
        if (done) begin
            scnt_d = batch_last ? '0 : scnt_q + CW'(1);
            if (batch_last) begin
                for (int unsigned k = 0; k < NSLOT; k++) begin
                    result_d[k] = 12'(acc_q[k] >> AVG_LOG2);
                    fresh_d[k]  = 1'b1;
                    acc_d[k]    = '0;
                end
            end
        end
        if ((state_q == IDLE) && start) begin
            scnt_d = '0;
            for (int unsigned k = 0; k < NSLOT; k++) acc_d[k] = '0;
        end
`endif
    end

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            state_q    <= IDLE;
            chans_q    <= '0;
            iss_ptr_q  <= '0;
            rsp_ptr_q  <= '0;
            outst_q    <= '0;
            gap_q      <= '0;
            result_q   <= '{default: '0};
            fresh_q    <= '0;
            rd_data_q  <= '0;
            rd_fresh_q <= 1'b0;
            seq_err_q  <= 1'b0;
`ifdef ADC_AVG_EN
            acc_q      <= '{default: '0};
            scnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            chans_q    <= chans_d;
            iss_ptr_q  <= iss_ptr_d;
            rsp_ptr_q  <= rsp_ptr_d;
            outst_q    <= outst_d;
            gap_q      <= gap_d;
            result_q   <= result_d;
            fresh_q    <= fresh_d;
            rd_data_q  <= rd_data_d;
            rd_fresh_q <= rd_fresh_d;
            seq_err_q  <= seq_err_d;
`ifdef ADC_AVG_EN
            acc_q      <= acc_d;
            scnt_q     <= scnt_d;
`endif
        end
    end

    assign command_valid         = cmd_valid;
    assign command_channel       = cmd_valid ? iss_chan : '0;
    assign command_startofpacket = cmd_valid;
    assign command_endofpacket   = cmd_valid;
    assign rd_data               = rd_data_q;
    assign rd_fresh              = rd_fresh_q;
    assign busy                  = (state_q != IDLE);
    assign scan_done             = done;
    assign seq_err               = seq_err_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: self-checking bench with an in-order ADC responder model for adc_scan_ctrl.
// With ADC_AVG_EN defined the averaging sequence runs instead of the overwrite-mode tests.
module tb_adc_scan_ctrl;
    localparam int NSLOT = 4, MAX_OUT = 2, SCAN_GAP = 16, AVG_LOG2 = 2;

    logic               clock_clk = 1'b0;
    logic               reset_sink_reset, start, continuous;
    logic [NSLOT*5-1:0] chan_list;
    logic               command_valid, command_startofpacket, command_endofpacket, command_ready;
    logic [4:0]         command_channel, response_channel;
    logic               response_valid, response_startofpacket, response_endofpacket;
    logic [11:0]        response_data, rd_data;
    logic               rd_en, rd_fresh, busy, scan_done, seq_err, clr_err;
    logic [1:0]         rd_slot;

    always #5 clock_clk = ~clock_clk;

    adc_scan_ctrl #(.NSLOT(NSLOT), .MAX_OUT(MAX_OUT), .SCAN_GAP(SCAN_GAP), .AVG_LOG2(AVG_LOG2)) dut (
        .clock_clk(clock_clk), .reset_sink_reset(reset_sink_reset), .start(start),
        .continuous(continuous), .chan_list(chan_list), .command_valid(command_valid),
        .command_channel(command_channel), .command_startofpacket(command_startofpacket),
        .command_endofpacket(command_endofpacket), .command_ready(command_ready),
        .response_valid(response_valid), .response_channel(response_channel),
        .response_data(response_data), .response_startofpacket(response_startofpacket),
        .response_endofpacket(response_endofpacket), .rd_en(rd_en), .rd_slot(rd_slot),
        .rd_data(rd_data), .rd_fresh(rd_fresh), .busy(busy), .scan_done(scan_done),
        .seq_err(seq_err), .clr_err(clr_err));

    typedef struct { int due; logic [4:0] ch; logic [11:0] data; } rsp_t;
    typedef struct { int slot; logic [11:0] data; logic fresh; } rdvec_t;

    rsp_t        pend [$];
    logic [4:0]  fired_ch [$];
    logic [4:0]  lst [NSLOT];
    logic [11:0] exp_res [NSLOT];
    logic [11:0] data_base;
    logic [4:0]  prev_ch, bad_val;
    rdvec_t      rtab [6];
    int checks = 0, failures = 0, cyc = 0;
    int n_fire = 0, n_done = 0, slot_idx = 0, bench_out = 0, max_out = 0;
    int hold_viol = 0, sop_viol = 0, done_cyc = 0, gap_meas = -1, rdy_idx = 0;
    int ready_mode = 0, lat_min = 2, lat_max = 2, bad_slot = -1, avg_base = 0;
    bit wait_v = 0, prev_stall = 0, rsp_en = 1, rand_data = 0, force_rsp = 0, avg_seq = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive this cycle's inputs, account fires/responses, advance past the edge.
    task automatic tick();
        rsp_t r;
        logic [11:0] d;
        response_valid = 1'b0; response_channel = '0; response_data = '0;
        if (force_rsp) begin
            response_valid = 1'b1; response_channel = 5'd3; response_data = 12'hABC;
        end else if (rsp_en && pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            response_valid = 1'b1; response_channel = r.ch; response_data = r.data;
            if (bench_out > 0) bench_out--;
        end
        case (ready_mode)
            0:       command_ready = 1'b1;
            1:       command_ready = pat[rdy_idx % 4];
            default: command_ready = ($urandom_range(0, 9) < 7);
        endcase
        rdy_idx++;
        if (prev_stall && (command_valid !== 1'b1 || command_channel !== prev_ch)) hold_viol++;
        if (command_valid === 1'b1 && !(command_startofpacket && command_endofpacket)) sop_viol++;
        prev_stall = (command_valid === 1'b1) && !command_ready;
        prev_ch    = command_channel;
        if (command_valid === 1'b1 && command_ready) begin
            if (avg_seq && slot_idx == 0) d = 12'(10 + n_done - avg_base);
            else if (rand_data)           d = 12'($urandom);
            else                          d = data_base + 12'(slot_idx);
            r.due  = cyc + int'($urandom_range(lat_min, lat_max));
            r.ch   = (slot_idx == bad_slot) ? bad_val : command_channel;
            r.data = d;
            pend.push_back(r);
            exp_res[slot_idx] = d;
            fired_ch.push_back(command_channel);
            n_fire++;
            bench_out++;
            if (bench_out > max_out) max_out = bench_out;
            slot_idx = (slot_idx + 1) % NSLOT;
        end
        if (scan_done === 1'b1) begin
            n_done++; done_cyc = cyc; wait_v = 1'b1;
        end else if (wait_v && command_valid === 1'b1) begin
            gap_meas = cyc - done_cyc; wait_v = 1'b0;
        end
        @(posedge clock_clk); #1;
        cyc++;
    endtask

    task automatic start_scan();
        chan_list = '0;
        for (int i = 0; i < NSLOT; i++) chan_list[5*i +: 5] = lst[i];
        fired_ch.delete();
        slot_idx = 0; rdy_idx = 0; max_out = 0; bench_out = 0; hold_viol = 0; sop_viol = 0;
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n0 = n_done;
        int i = 0;
        while (n_done == n0 && i < budget) begin tick(); i++; end
        chk(name, 32'(n_done - n0), 32'd1);
    endtask

    task automatic do_read(input int slot, input logic [11:0] ed, input logic ef, input string name);
        rd_en = 1'b1; rd_slot = 2'(slot);
        tick();
        rd_en = 1'b0;
        chk(name, {19'd0, rd_fresh, rd_data}, {19'd0, ef, ed});
    endtask

    function automatic logic [31:0] fired_pack();
        logic [31:0] v = '0;
        foreach (fired_ch[i]) if (i < NSLOT) v[5*i +: 5] = fired_ch[i];
        return v;
    endfunction

    initial begin
        int i;
        rtab[0] = '{slot: 0, data: 12'h100, fresh: 1'b1};
        rtab[1] = '{slot: 1, data: 12'h101, fresh: 1'b1};
        rtab[2] = '{slot: 2, data: 12'h102, fresh: 1'b1};
        rtab[3] = '{slot: 3, data: 12'h103, fresh: 1'b1};
        rtab[4] = '{slot: 2, data: 12'h102, fresh: 1'b0};
        rtab[5] = '{slot: 0, data: 12'h100, fresh: 1'b0};

        reset_sink_reset = 1'b1; start = 1'b0; continuous = 1'b0; chan_list = '0;
        command_ready = 1'b0; response_valid = 1'b0; response_channel = '0; response_data = '0;
        response_startofpacket = 1'b0; response_endofpacket = 1'b0;
        rd_en = 1'b0; rd_slot = '0; clr_err = 1'b0; data_base = '0; bad_val = '0;
        @(posedge clock_clk); #1;
        tick(); tick();
        reset_sink_reset = 1'b0;
        tick();
        chk("reset_cmd", {24'd0, command_valid, command_channel, command_startofpacket, command_endofpacket}, 32'd0);
        chk("reset_status", {28'd0, busy, scan_done, seq_err, rd_fresh}, 32'd0);
        chk("reset_rd_data", {20'd0, rd_data}, 32'd0);

`ifdef ADC_AVG_EN
        lst = '{5'd0, 5'd1, 5'd2, 5'd3}; data_base = 12'h100;
        avg_seq = 1'b1; avg_base = n_done; continuous = 1'b1;
        start_scan();
        for (int s = 0; s < 3; s++) begin
            wait_done(300, "avg_scan");
            do_read(0, 12'h000, 1'b0, "avg_not_fresh");
        end
        i = 0;
        while (command_valid !== 1'b1 && i < 40) begin tick(); i++; end
        chk("avg_rescan", {31'd0, command_valid}, 32'd1);
        continuous = 1'b0;
        wait_done(300, "avg_scan4");
        do_read(0, 12'd11, 1'b1, "avg_result");
        chk("avg_idle", {31'd0, busy}, 32'd0);
`else
        // Single scan
        lst = '{5'd0, 5'd1, 5'd2, 5'd3}; data_base = 12'h100;
        start_scan();
        chk("start_latency", {26'd0, command_valid, command_channel}, {26'd0, 1'b1, 5'd0});
        wait_done(200, "single_done");
        chk("single_idle", {30'd0, busy, scan_done}, 32'd0);
        chk("single_order", fired_pack(), 32'(chan_list));
        chk("single_count", 32'(fired_ch.size()), 32'(NSLOT));
        chk("single_max_out", 32'(max_out), 32'(MAX_OUT));
        chk("single_sop_eop", 32'(sop_viol), 32'd0);
        chk("single_no_err", {31'd0, seq_err}, 32'd0);
        for (int t = 0; t < 6; t++) do_read(rtab[t].slot, rtab[t].data, rtab[t].fresh, "read_table");

        // Backpressure
        lst = '{5'd9, 5'd17, 5'd4, 5'd30}; data_base = 12'h200; ready_mode = 1;
        i = n_fire;
        start_scan();
        wait_done(200, "bp_done");
        chk("bp_hold", 32'(hold_viol), 32'd0);
        chk("bp_fires", 32'(n_fire - i), 32'd4);
        chk("bp_order", fired_pack(), 32'(chan_list));
        do_read(3, 12'h203, 1'b1, "bp_read");
        ready_mode = 0;

        // Continuous mode: gap, then drop mid-scan
        lst = '{5'd5, 5'd6, 5'd7, 5'd8}; data_base = 12'h300; continuous = 1'b1;
        start_scan();
        wait_done(200, "cont_done1");
        i = 0;
        while (wait_v && i < 40) begin tick(); i++; end
        chk("cont_gap", 32'(gap_meas), 32'(SCAN_GAP + 1));
        continuous = 1'b0;
        wait_done(200, "cont_done2");
        i = n_fire;
        for (int k = 0; k < 40; k++) tick();
        chk("cont_stopped", {31'd0, busy}, 32'd0);
        chk("cont_no_fire", 32'(n_fire - i), 32'd0);
        do_read(2, 12'h302, 1'b1, "cont_read");

        // Errors: wrong channel on slot 1, stray response, clear priority
        lst = '{5'd0, 5'd1, 5'd2, 5'd3}; data_base = 12'h400; bad_slot = 1; bad_val = 5'd7;
        start_scan();
        wait_done(200, "err_done");
        bad_slot = -1;
        chk("err_chan", {31'd0, seq_err}, 32'd1);
        do_read(1, 12'h401, 1'b1, "err_stored");
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("err_clear", {31'd0, seq_err}, 32'd0);
        force_rsp = 1'b1; tick(); force_rsp = 1'b0;
        chk("err_stray", {31'd0, seq_err}, 32'd1);
        do_read(0, 12'h400, 1'b1, "stray_dropped");
        force_rsp = 1'b1; clr_err = 1'b1; tick(); force_rsp = 1'b0; clr_err = 1'b0;
        chk("err_beats_clr", {31'd0, seq_err}, 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("err_clear2", {31'd0, seq_err}, 32'd0);

        // Read colliding with a response write to the same slot
        data_base = 12'h600; rsp_en = 1'b0;
        start_scan();
        i = 0;
        while (bench_out < 2 && i < 20) begin tick(); i++; end
        chk("collide_setup", 32'(bench_out), 32'd2);
        rsp_en = 1'b1; rd_en = 1'b1; rd_slot = 2'd0;
        tick();
        rd_en = 1'b0;
        chk("collide_old", {19'd0, rd_fresh, rd_data}, {19'd0, 1'b0, 12'h400});
        wait_done(200, "collide_done");
        do_read(0, 12'h600, 1'b1, "collide_fresh");

        // Reset with two commands outstanding
        data_base = 12'h500; rsp_en = 1'b0;
        start_scan();
        i = 0;
        while (bench_out < 2 && i < 20) begin tick(); i++; end
        chk("rst_setup", 32'(bench_out), 32'd2);
        reset_sink_reset = 1'b1; tick(); reset_sink_reset = 1'b0;
        bench_out = 0; slot_idx = 0;
        chk("rst_cmd", {24'd0, command_valid, command_channel, command_startofpacket, command_endofpacket}, 32'd0);
        chk("rst_status", {16'd0, busy, scan_done, seq_err, rd_fresh, rd_data}, 32'd0);
        rsp_en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_late_err", {31'd0, seq_err}, 32'd1);
        do_read(0, 12'h000, 1'b0, "rst_late_drop0");
        do_read(1, 12'h000, 1'b0, "rst_late_drop1");

        // Randomized scans against the responder model
        ready_mode = 2; lat_min = 1; lat_max = 5; rand_data = 1'b1;
        for (int n = 0; n < 12; n++) begin
            clr_err = 1'b1; tick(); clr_err = 1'b0;
            for (int k = 0; k < NSLOT; k++) lst[k] = 5'($urandom);
            bad_slot = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NSLOT - 1)) : -1;
            if (bad_slot >= 0) bad_val = lst[bad_slot] ^ 5'd1;
            start_scan();
            wait_done(400, "rnd_done");
            chk("rnd_order", fired_pack(), 32'(chan_list));
            chk("rnd_hold", 32'(hold_viol), 32'd0);
            chk("rnd_max_out", 32'(max_out <= MAX_OUT), 32'd1);
            chk("rnd_seq_err", {31'd0, seq_err}, 32'(bad_slot >= 0));
            for (int k = 0; k < NSLOT; k++) do_read(k, exp_res[k], 1'b1, "rnd_read");
        end
        bad_slot = -1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
